// File: rtl/nco_tune_ctrl_if.sv
// ---------------------------------------------------------------------------
// nco_tune_ctrl_if
// Command channel between the host/config logic and the NCO tuning
// controller. A command transfers on a clock edge where cmd_valid and
// cmd_ready are both high.
//
// Signals
//   cmd_valid     host -> ctrl   command present
//   cmd_ready     ctrl -> host   controller can accept a command
//   cmd_target    host -> ctrl   target phase increment (unsigned)
//   cmd_step      host -> ctrl   ramp step magnitude, 0 means jump at once
//   cmd_tick_div  host -> ctrl   ramp cadence, one step per (div+1) clocks
//
// Modports
//   master  host side (drives the command fields)
//   slave   controller side (drives cmd_ready)
// ---------------------------------------------------------------------------
interface nco_tune_ctrl_if #(
    parameter int REGISTER_WIDTH = 64,
    parameter int DIV_WIDTH      = 16
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [REGISTER_WIDTH-1:0] cmd_target;
    logic [REGISTER_WIDTH-1:0] cmd_step;
    logic [DIV_WIDTH-1:0]      cmd_tick_div;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_step,
        output cmd_tick_div,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_step,
        input  cmd_tick_div,
        output cmd_ready
    );
endinterface

// File: rtl/nco_tune_ctrl.sv
// ---------------------------------------------------------------------------
// nco_tune_ctrl
// Sequences the phase_increment word of an NCO phase accumulator. A tuning
// command either jumps the increment straight to a new value or glides it
// linearly toward the target in fixed steps, one step every (tick_div+1)
// clocks, never overshooting and never wrapping.
//
// Ports
//   clk              in   single clock for all logic
//   rst              in   asynchronous, active-high reset
//   cmd              --   command channel (nco_tune_ctrl_if.slave)
//   abort            in   stop a ramp in progress, hold the current increment
//   phase_increment  out  registered increment driving the NCO
//   busy             out  ramp in progress
//   done             out  one-clock pulse when the target is reached
// ---------------------------------------------------------------------------
module nco_tune_ctrl #(
    parameter int                        REGISTER_WIDTH  = 64,
    parameter int                        DIV_WIDTH       = 16,
    parameter logic [REGISTER_WIDTH-1:0] RESET_INCREMENT = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    nco_tune_ctrl_if.slave            cmd,
    input  logic                      abort,
    output logic [REGISTER_WIDTH-1:0] phase_increment,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t                    state;
    logic                      ready_q;
    logic                      dir_up;
    logic [REGISTER_WIDTH-1:0] target_q;
    logic [REGISTER_WIDTH-1:0] step_q;
    logic [DIV_WIDTH-1:0]      div_q;
    logic [DIV_WIDTH-1:0]      tick_cnt;
    logic [REGISTER_WIDTH-1:0] remaining;
    logic                      immediate;

    assign cmd.cmd_ready = ready_q;

    // Distance still to travel, taken in the direction fixed at accept so it
    // is always non-negative. Comparing this against the step (rather than
    // adding the step first) is what keeps the increment from wrapping.
    always_comb begin
        remaining = '0;
        if (dir_up) begin
            remaining = target_q - phase_increment;
        end else begin
            remaining = phase_increment - target_q;
        end
    end

    // A zero step, or a target equal to the current increment, needs no
    // ramp: the new value is applied on the accept edge itself.
    assign immediate = (cmd.cmd_step == '0) || (cmd.cmd_target == phase_increment);

    // Control FSM with all outputs registered. In IDLE a valid command is
    // accepted (cmd_ready is high for the whole of IDLE). In RAMP the tick
    // counter paces the steps; abort has priority over a step falling due on
    // the same edge, and the step that lands on the target finishes the ramp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            phase_increment <= RESET_INCREMENT;
            busy            <= 1'b0;
            done            <= 1'b0;
            ready_q         <= 1'b1;
            tick_cnt        <= '0;
            target_q        <= '0;
            step_q          <= '0;
            div_q           <= '0;
            dir_up          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        if (immediate) begin
                            phase_increment <= cmd.cmd_target;
                            done            <= 1'b1;
                        end else begin
                            state    <= RAMP;
                            busy     <= 1'b1;
                            ready_q  <= 1'b0;
                            tick_cnt <= '0;
                            target_q <= cmd.cmd_target;
                            step_q   <= cmd.cmd_step;
                            div_q    <= cmd.cmd_tick_div;
                            dir_up   <= (cmd.cmd_target > phase_increment);
                        end
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (tick_cnt == div_q) begin
                        tick_cnt <= '0;
                        if (remaining <= step_q) begin
                            phase_increment <= target_q;
                            done            <= 1'b1;
                            state           <= IDLE;
                            busy            <= 1'b0;
                            ready_q         <= 1'b1;
                        end else if (dir_up) begin
                            phase_increment <= phase_increment + step_q;
                        end else begin
                            phase_increment <= phase_increment - step_q;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nco_tune_ctrl
// Self-checking bench for nco_tune_ctrl. The driver issues commands and, at
// each accept, a reference model pushes every expected phase_increment
// change / done pulse (value, done flag, clock edge) into a queue. A
// separate monitor pops and compares whenever the DUT's increment changes or
// done is high. Directed cases cover reset, jump, ramp up/down, abort and
// the held-valid handshake; a randomized loop follows.
// ---------------------------------------------------------------------------
module tb_nco_tune_ctrl;

    localparam int RW = 64;
    localparam int DW = 16;

    typedef struct {
        logic [RW-1:0] val;
        logic          done_flag;
        int            edge_n;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          abort;
    logic [RW-1:0] phase_increment;
    logic          busy;
    logic          done;

    ev_t           exp_q[$];
    logic [RW-1:0] model_cur;
    logic [RW-1:0] prev_inc;
    int            cyc;
    int            n_checks;
    int            n_pass;
    int            last_end_edge;

    nco_tune_ctrl_if #(.REGISTER_WIDTH(RW), .DIV_WIDTH(DW)) cmd_if ();

    nco_tune_ctrl #(
        .REGISTER_WIDTH (RW),
        .DIV_WIDTH      (DW),
        .RESET_INCREMENT('0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd            (cmd_if),
        .abort          (abort),
        .phase_increment(phase_increment),
        .busy           (busy),
        .done           (done)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after the n-th rising edge cyc holds n.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Global time limit so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [RW-1:0] actual,
                               input logic [RW-1:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h expected=%0h (t=%0t cyc=%0d)",
                     name, actual, expected, $time, cyc);
        end
    endtask

    // Reference model: from the start value, target and step work out the
    // whole list of increments the ramp must visit (start + i*step, last one
    // clamped to the target), each landing (div+1) edges after the previous.
    // Events at or after a planned abort edge never happen and are dropped.
    task automatic pushModel(input logic [RW-1:0] t, input logic [RW-1:0] st,
                             input logic [DW-1:0] dv, input int k,
                             input int abort_m, output bit ramp);
        logic [RW-1:0] s;
        logic [RW-1:0] diff;
        logic [RW-1:0] nsteps;
        logic [RW-1:0] v;
        bit            up;
        int            n;
        int            e;
        ev_t           ev;
        s = model_cur;
        if (st == '0 || t == s) begin
            ev.val       = t;
            ev.done_flag = 1'b1;
            ev.edge_n    = k;
            exp_q.push_back(ev);
            model_cur = t;
            ramp = 1'b0;
        end else begin
            ramp   = 1'b1;
            up     = (t > s);
            diff   = up ? (t - s) : (s - t);
            nsteps = diff / st + ((diff % st) != '0 ? 64'd1 : 64'd0);
            n      = int'(nsteps);
            for (int i = 1; i <= n; i++) begin
                e = k + i * (int'(dv) + 1);
                if (abort_m > 0 && e >= k + abort_m) break;
                if (i == n) begin
                    v = t;
                end else if (up) begin
                    v = s + RW'(i) * st;
                end else begin
                    v = s - RW'(i) * st;
                end
                ev.val       = v;
                ev.done_flag = (i == n);
                ev.edge_n    = e;
                exp_q.push_back(ev);
                model_cur     = v;
                last_end_edge = e;
            end
        end
    endtask

    // Drive one command (valid held until the DUT is ready), push the model's
    // expectations at the accept edge, scramble the fields afterwards and, if
    // requested, pulse abort so that it is sampled abort_m edges after accept.
    task automatic applyStimulus(input logic [RW-1:0] t, input logic [RW-1:0] st,
                                 input logic [DW-1:0] dv, input int abort_m,
                                 input bit abort_with_cmd, output int k);
        int waited;
        bit ramp;
        @(negedge clk);
        cmd_if.cmd_target   = t;
        cmd_if.cmd_step     = st;
        cmd_if.cmd_tick_div = dv;
        cmd_if.cmd_valid    = 1'b1;
        abort               = abort_with_cmd;
        waited = 0;
        while (cmd_if.cmd_ready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            checkOutput("accept_timeout", 64'(waited), 64'd0);
            cmd_if.cmd_valid = 1'b0;
            abort            = 1'b0;
            k = -1;
            return;
        end
        k = cyc + 1;
        pushModel(t, st, dv, k, abort_m, ramp);
        @(negedge clk);
        cmd_if.cmd_valid    = 1'b0;
        abort               = 1'b0;
        cmd_if.cmd_target   = {$urandom, $urandom};
        cmd_if.cmd_step     = {$urandom, $urandom};
        cmd_if.cmd_tick_div = DW'($urandom);
        if (!ramp) begin
            checkOutput("busy_after_jump", 64'(busy), 64'd0);
            checkOutput("ready_after_jump", 64'(cmd_if.cmd_ready), 64'd1);
        end else if (abort_m != 1 && dv != '0) begin
            checkOutput("busy_in_ramp", 64'(busy), 64'd1);
            checkOutput("ready_in_ramp", 64'(cmd_if.cmd_ready), 64'd0);
        end
        if (ramp && abort_m > 0) begin
            while (cyc < k + abort_m - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            checkOutput("busy_after_abort", 64'(busy), 64'd0);
            checkOutput("ready_after_abort", 64'(cmd_if.cmd_ready), 64'd1);
            checkOutput("done_after_abort", 64'(done), 64'd0);
            checkOutput("held_after_abort", phase_increment, model_cur);
        end
    endtask

    task automatic waitIdle();
        int w;
        w = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) checkOutput("idle_timeout", 64'(w), 64'd0);
        @(negedge clk);
    endtask

    // Monitor: any change of phase_increment or any done pulse is an output
    // event and must match the head of the expectation queue, including the
    // edge on which it landed. Reset periods are skipped and resynchronised.
    always @(negedge clk) begin
        ev_t ev;
        if (rst) begin
            prev_inc = phase_increment;
        end else begin
            if (phase_increment !== prev_inc || done !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_event_qsize", 64'(exp_q.size()), 64'd1);
                end else begin
                    ev = exp_q.pop_front();
                    checkOutput("inc", phase_increment, ev.val);
                    checkOutput("done", 64'(done), 64'(ev.done_flag));
                    checkOutput("edge", 64'(cyc), 64'(ev.edge_n));
                end
            end
            prev_inc = phase_increment;
        end
    end

    initial begin
        int k;
        int k2;
        int end1;
        logic [RW-1:0] t;
        logic [RW-1:0] st;
        logic [RW-1:0] diff;
        logic [DW-1:0] dv;
        int mode;
        int am;

        n_checks = 0;
        n_pass   = 0;
        last_end_edge = 0;
        model_cur = '0;
        prev_inc  = '0;
        rst   = 1'b1;
        abort = 1'b0;
        cmd_if.cmd_valid    = 1'b0;
        cmd_if.cmd_target   = '0;
        cmd_if.cmd_step     = '0;
        cmd_if.cmd_tick_div = '0;

        // Reset values while reset is held.
        @(posedge clk);
        #3;
        checkOutput("reset_inc", phase_increment, 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_ready", 64'(cmd_if.cmd_ready), 64'd1);
        checkOutput("reset_done", 64'(done), 64'd0);
        #4 rst = 1'b0;

        // Reset asserted mid-cycle in the middle of a ramp.
        $display("[TB] reset mid-ramp");
        applyStimulus(64'd1000, 64'd10, 16'd0, 0, 1'b0, k);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_inc", phase_increment, 64'd0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_ready", 64'(cmd_if.cmd_ready), 64'd1);
        exp_q.delete();
        model_cur = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("postreset_inc", phase_increment, 64'd0);

        // Immediate jump.
        $display("[TB] immediate jump");
        applyStimulus(64'h1000, 64'd0, 16'd5, 0, 1'b0, k);
        waitIdle();

        // Ramp up 0 -> 10 in steps of 3, one step every 2 clocks.
        $display("[TB] ramp up");
        applyStimulus(64'd0, 64'd0, 16'd0, 0, 1'b0, k);
        applyStimulus(64'd10, 64'd3, 16'd1, 0, 1'b0, k);
        waitIdle();
        checkOutput("ramp_up_final", phase_increment, 64'd10);

        // Ramp down 2 -> 0 with a step larger than the distance.
        $display("[TB] ramp down wrap guard");
        applyStimulus(64'd2, 64'd0, 16'd0, 0, 1'b0, k);
        applyStimulus(64'd0, 64'd5, 16'd0, 0, 1'b0, k);
        waitIdle();
        checkOutput("ramp_down_final", phase_increment, 64'd0);

        // Abort after the 2nd step, then an immediate command.
        $display("[TB] abort");
        applyStimulus(64'd100, 64'd10, 16'd3, 10, 1'b0, k);
        checkOutput("abort_hold", phase_increment, 64'd20);
        applyStimulus(64'h55, 64'd0, 16'd0, 0, 1'b0, k);
        waitIdle();

        // Abort on the very edge a step is due: the step must not land.
        applyStimulus(64'd200, 64'd50, 16'd1, 4, 1'b0, k);
        waitIdle();

        // Abort held while idle does not block an accept.
        $display("[TB] abort in idle");
        applyStimulus(64'h95, 64'd16, 16'd0, 0, 1'b1, k);
        waitIdle();

        // Valid held through a ramp: second command waits for done.
        $display("[TB] held valid handshake");
        applyStimulus(64'h15, 64'd7, 16'd2, 0, 1'b0, k);
        end1 = last_end_edge;
        applyStimulus(64'h40000, 64'd0, 16'd0, 0, 1'b0, k2);
        checkOutput("handshake_accept_edge", 64'(k2), 64'(end1 + 1));
        waitIdle();

        // Randomized commands.
        $display("[TB] random commands");
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 9);
            t    = {$urandom, $urandom};
            dv   = DW'($urandom_range(0, 3));
            am   = 0;
            if (mode < 2) begin
                st = '0;
            end else if (mode == 2) begin
                t  = model_cur;
                st = 64'(($urandom_range(1, 100)));
            end else begin
                diff = (t > model_cur) ? (t - model_cur) : (model_cur - t);
                st   = diff / 64'($urandom_range(1, 8)) + 64'd1;
                if (mode >= 8) am = $urandom_range(1, 30);
            end
            applyStimulus(t, st, dv, am, 1'b0, k);
        end
        waitIdle();
        checkOutput("final_inc", phase_increment, model_cur);
        checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
